piso_transmitter: RTL and testbench

- Parallel-in, serial-out transmitter for the storage components of the datapath.
- Captures a WIDTH-bit word on a load enable, then drives it out one bit per clock, LSB first, on Q.
- Raises a one-cycle done pulse when the last bit has been driven.
- Serves as the read-out end of the enabled-register family and feeds serial links and sequential consumers.

---
 rtl/piso_transmitter.sv | 79 +++++++
 tb/tb_piso_transmitter.sv | 119 +++++++++++
 2 files changed

// File: rtl/piso_transmitter.sv
// piso_transmitter: loads a WIDTH-bit word on E and shifts it out LSB first on Q.
// Pulses done for one cycle after the last bit. A load is also accepted in the done cycle.
module piso_transmitter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             E,
    output logic             Q,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_q, q_d, busy_q, busy_d, done_q, done_d;

    // The shift register holds the bits not yet on Q, so sr_q[0] is always the next bit.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        q_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    q_d    = sr_q[0];
                    sr_d   = sr_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                if (E) begin
                    state_d = SHIFT;
                    sr_d    = D >> 1;
                    cnt_d   = '0;
                    q_d     = D[0];
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_piso_transmitter.sv
// tb_piso_transmitter: scoreboard bench; the driver queues the expected serial frames and a monitor pops them.
module tb_piso_transmitter;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] D = '0;
    logic             E = 1'b0;
    logic             Q, busy, done;

    int total = 0;
    int passed = 0;
    int rem = 0;
    logic [2:0] exp_q[$];

    piso_transmitter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .D(D), .E(E), .Q(Q), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference: a word occupies WIDTH busy cycles plus one done cycle; a new load is
    // taken only when nothing is in flight or during that done cycle.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            if (E === 1'b1 && rem <= 1) begin
                for (int k = 0; k < WIDTH; k++) exp_q.push_back({D[k], 2'b10});
                exp_q.push_back(3'b001);
                rem = WIDTH + 1;
            end else if (rem > 0) begin
                rem--;
            end
        end
        #2;
    endtask

    task automatic reset_pulse();
        #1 reset = 1'b0;
        exp_q.delete();
        rem = 0;
        #1;
        check("rst_q", Q, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #3 reset = 1'b1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input int idle);
        E = 1'b1;
        D = w;
        tick();
        E = 1'b0;
        repeat (idle) tick();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (busy || done || exp_q.size() > 0) begin
                if (exp_q.size() == 0) check("unexpected_out", {Q, busy, done}, 0);
                else check("stream", {Q, busy, done}, exp_q.pop_front());
            end else begin
                check("idle_q", Q, 0);
            end
            check("busy_done_excl", busy & done, 0);
        end
    end

    initial begin
        #2 reset = 1'b0;
        D = 8'hFF;
        E = 1'b1;
        #3;
        check("init_q", Q, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        #10 reset = 1'b1;
        E = 1'b0;
        D = 8'hA5;
        repeat (3) tick();
        send(8'hA5, 10);
        send(8'h3C, 2);
        E = 1'b1;
        D = 8'h00;
        repeat (2) tick();
        E = 1'b0;
        repeat (8) tick();
        send(8'h01, 8);
        E = 1'b1;
        D = 8'h81;
        tick();
        check("b2b_q", Q, 1);
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        E = 1'b0;
        repeat (10) tick();
        send(8'hF0, 4);
        reset_pulse();
        repeat (12) tick();
        send(8'h0F, 10);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) reset_pulse();
            E = ($urandom_range(0, 2) == 0);
            D = WIDTH'($urandom);
            tick();
        end
        E = 1'b0;
        repeat (WIDTH + 3) tick();
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
